// File: rtl/exp_in_cond_pkg.sv
// Shared constants for the expansion-connector input conditioner:
// register offsets and the STATUS/MASK field layout.
package exp_in_pkg;

    localparam logic [19:0] ADDR_DB_LEN = 20'h0_0000;
    localparam logic [19:0] ADDR_STATUS = 20'h0_0004;
    localparam logic [19:0] ADDR_MASK   = 20'h0_0008;
    localparam logic [19:0] ADDR_LEVEL  = 20'h0_000C;

    // STATUS/MASK are four DWE-wide fields, lowest first.
    localparam int P_RISE_IDX = 0;
    localparam int P_FALL_IDX = 1;
    localparam int N_RISE_IDX = 2;
    localparam int N_FALL_IDX = 3;

    // Bit index where a field starts for a given connector width.
    function automatic int field_base(input int idx, input int dwe);
        return idx * dwe;
    endfunction

endpackage

// File: rtl/exp_in_cond_if.sv
// Simple register bus: one-cycle strobes, registered ack and read data.
interface exp_in_cond_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        input  sys_rdata, sys_err, sys_ack
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        output sys_rdata, sys_err, sys_ack
    );
endinterface

// File: rtl/exp_in_cond_db.sv
// One connector bit: 2-flop synchronizer, counting debounce and
// single-cycle rise/fall pulses coincident with the edge that updates d.
module exp_in_db #(
    parameter int DBW = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           pin_i,
    input  logic [DBW-1:0] len_i,
    input  logic           clr_cnt_i,
    output logic           dat_o,
    output logic           rise_o,
    output logic           fall_o
);

    logic           s1;
    logic           s2;
    logic           d;
    logic [DBW-1:0] c;
    logic [DBW-1:0] lm1;
    logic           upd;

    // A length of 0 behaves like 1 so the bypass setting still needs one agreeing edge.
    assign lm1 = (len_i == '0) ? '0 : len_i - DBW'(1);

    // A counter clear (length rewrite) takes priority and holds d for that edge.
    assign upd    = (s2 != d) && (c >= lm1) && !clr_cnt_i;
    assign rise_o = upd & s2;
    assign fall_o = upd & ~s2;
    assign dat_o  = d;

    // Synchronize the raw pin, then accept a new level once it has been stable long enough.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d  <= 1'b0;
            c  <= '0;
        end else begin
            s1 <= pin_i;
            s2 <= s1;
            if (clr_cnt_i || (s2 == d)) begin
                c <= '0;
            end else if (c >= lm1) begin
                d <= s2;
                c <= '0;
            end else begin
                c <= c + DBW'(1);
            end
        end
    end

endmodule

// File: rtl/exp_in_cond.sv
// Expansion-connector input conditioner: debounces both connector sides,
// latches edge events into a W1C status register and raises a masked,
// registered level interrupt.
module exp_in_cond
    import exp_in_pkg::*;
#(
    parameter int DWE = 8,
    parameter int DBW = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [DWE-1:0] exp_p_pin_i,
    input  logic [DWE-1:0] exp_n_pin_i,
    output logic [DWE-1:0] exp_p_dat_o,
    output logic [DWE-1:0] exp_n_dat_o,
    output logic           irq_o,
    exp_in_cond_if.slave   bus
);

    localparam int SW = 4 * DWE;

    logic [DBW-1:0] db_len;
    logic [SW-1:0]  status;
    logic [SW-1:0]  mask;
    logic [SW-1:0]  set_vec;
    logic [SW-1:0]  clr_vec;
    logic [DWE-1:0] p_rise, p_fall, n_rise, n_fall;
    logic [19:0]    addr;
    logic           wr_db, wr_status, wr_mask;
    logic [31:0]    rd_mux;
    logic [31:0]    rdata_q;
    logic           ack_q;
    logic           unused_bits;

    genvar gi;
    generate
        for (gi = 0; gi < DWE; gi++) begin : g_ch
            exp_in_db #(.DBW(DBW)) u_p (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .pin_i     (exp_p_pin_i[gi]),
                .len_i     (db_len),
                .clr_cnt_i (wr_db),
                .dat_o     (exp_p_dat_o[gi]),
                .rise_o    (p_rise[gi]),
                .fall_o    (p_fall[gi])
            );
            exp_in_db #(.DBW(DBW)) u_n (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .pin_i     (exp_n_pin_i[gi]),
                .len_i     (db_len),
                .clr_cnt_i (wr_db),
                .dat_o     (exp_n_dat_o[gi]),
                .rise_o    (n_rise[gi]),
                .fall_o    (n_fall[gi])
            );
        end
    endgenerate

    assign addr      = bus.sys_addr[19:0];
    assign wr_db     = bus.sys_wen && (addr == ADDR_DB_LEN);
    assign wr_status = bus.sys_wen && (addr == ADDR_STATUS);
    assign wr_mask   = bus.sys_wen && (addr == ADDR_MASK);

    always_comb begin
        set_vec = '0;
        set_vec[field_base(P_RISE_IDX, DWE) +: DWE] = p_rise;
        set_vec[field_base(P_FALL_IDX, DWE) +: DWE] = p_fall;
        set_vec[field_base(N_RISE_IDX, DWE) +: DWE] = n_rise;
        set_vec[field_base(N_FALL_IDX, DWE) +: DWE] = n_fall;
    end

    assign clr_vec = wr_status ? bus.sys_wdata[SW-1:0] : '0;

    // Read mux; unmapped offsets return zero.
    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_DB_LEN: rd_mux = 32'(db_len);
            ADDR_STATUS: rd_mux = 32'(status);
            ADDR_MASK:   rd_mux = 32'(mask);
            ADDR_LEVEL:  rd_mux = 32'({exp_n_dat_o, exp_p_dat_o});
            default:     rd_mux = '0;
        endcase
    end

    // Config/status registers, interrupt and bus response; a same-edge event beats a W1C clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            db_len  <= '0;
            status  <= '0;
            mask    <= '0;
            irq_o   <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (wr_db)   db_len <= bus.sys_wdata[DBW-1:0];
            if (wr_mask) mask   <= bus.sys_wdata[SW-1:0];
            status  <= (status & ~clr_vec) | set_vec;
            irq_o   <= |(status & mask);
            ack_q   <= bus.sys_wen | bus.sys_ren;
            rdata_q <= bus.sys_ren ? rd_mux : '0;
        end
    end

    assign bus.sys_ack   = ack_q;
    assign bus.sys_rdata = rdata_q;
    assign bus.sys_err   = 1'b0;

    // Byte selects are ignored and only the low address bits are decoded.
    assign unused_bits = ^{bus.sys_addr[31:20], bus.sys_sel, bus.sys_wdata};

endmodule

// File: tb/tb_exp_in_cond.sv
// Directed bench for exp_in_cond with immediate-assertion checks.
module tb_exp_in_cond;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_pin, n_pin;
    logic [7:0] p_dat, n_dat;
    logic       irq;
    int         total = 0;
    int         bad   = 0;

    exp_in_cond_if bus_if ();

    exp_in_cond #(.DWE(8), .DBW(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .exp_p_pin_i (p_pin),
        .exp_n_pin_i (n_pin),
        .exp_p_dat_o (p_dat),
        .exp_n_dat_o (n_dat),
        .irq_o       (irq),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] dt);
        bus_if.sys_addr  = a;
        bus_if.sys_wdata = dt;
        bus_if.sys_wen   = 1'b1;
        @(posedge clk);
        #1;
        chk("wr_ack", 32'(bus_if.sys_ack), 32'd1);
        chk("wr_err", 32'(bus_if.sys_err), 32'd0);
        bus_if.sys_wen = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
        bus_if.sys_addr = a;
        bus_if.sys_ren  = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_ack"}, 32'(bus_if.sys_ack), 32'd1);
        chk({tag, "_err"}, 32'(bus_if.sys_err), 32'd0);
        chk(tag, bus_if.sys_rdata, exp);
        bus_if.sys_ren = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        p_pin = '0;
        n_pin = '0;
        bus_if.sys_addr  = '0;
        bus_if.sys_wdata = '0;
        bus_if.sys_sel   = 4'hF;
        bus_if.sys_wen   = 1'b0;
        bus_if.sys_ren   = 1'b0;

        // reset state
        tick(3);
        chk("rst_p_dat", 32'(p_dat), 32'd0);
        chk("rst_n_dat", 32'(n_dat), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ack", 32'(bus_if.sys_ack), 32'd0);
        chk("rst_rdata", bus_if.sys_rdata, 32'd0);
        rst = 1'b0;
        rd(32'h00, "db_len_rst", 32'd0);
        rd(32'h04, "status_rst", 32'd0);

        // DB_LEN=0: P0 rises three edges after first sample
        p_pin[0] = 1'b1;
        tick(2);
        chk("p0_lat2", 32'(p_dat), 32'h00);
        tick(1);
        chk("p0_lat3", 32'(p_dat), 32'h01);
        tick(2);
        chk("p0_irq_masked", 32'(irq), 32'd0);
        rd(32'h04, "status_p0", 32'h0000_0001);
        wr(32'h04, 32'hFFFF_FFFF);
        rd(32'h04, "status_clr", 32'd0);

        // DB_LEN=5: 4-cycle glitch rejected, 6-cycle pulse accepted
        wr(32'h00, 32'd5);
        n_pin[3] = 1'b1;
        tick(4);
        n_pin[3] = 1'b0;
        tick(10);
        chk("n3_glitch", 32'(n_dat), 32'h00);
        rd(32'h04, "status_glitch", 32'd0);
        n_pin[3] = 1'b1;
        tick(6);
        n_pin[3] = 1'b0;
        chk("n3_lat6", 32'(n_dat), 32'h00);
        tick(1);
        chk("n3_lat7", 32'(n_dat), 32'h08);
        tick(10);
        chk("n3_fell", 32'(n_dat), 32'h00);
        rd(32'h04, "status_n3", 32'h0808_0000);
        wr(32'h04, 32'hFFFF_FFFF);

        // masked P2 fall drives irq one edge after the status bit
        p_pin[2] = 1'b1;
        tick(12);
        wr(32'h04, 32'hFFFF_FFFF);
        wr(32'h08, 32'h0000_FF00);
        p_pin[2] = 1'b0;
        tick(6);
        chk("p2_hold", 32'(p_dat), 32'h05);
        tick(1);
        chk("p2_fell", 32'(p_dat), 32'h01);
        chk("irq_not_yet", 32'(irq), 32'd0);
        tick(1);
        chk("irq_set", 32'(irq), 32'd1);
        rd(32'h04, "status_p2f", 32'h0000_0400);
        wr(32'h04, 32'h0000_0400);
        tick(1);
        chk("irq_clr", 32'(irq), 32'd0);

        // rise event and W1C of the same bit on the same edge
        wr(32'h00, 32'd0);
        p_pin[1] = 1'b1;
        tick(2);
        wr(32'h04, 32'h0000_0002);
        rd(32'h04, "set_beats_clr", 32'h0000_0002);
        wr(32'h04, 32'hFFFF_FFFF);

        // DB_LEN rewrite at count 60 restarts the full 100-cycle count
        wr(32'h00, 32'd100);
        p_pin[3] = 1'b1;
        tick(62);
        chk("p3_pre_rewrite", 32'(p_dat), 32'h03);
        wr(32'h00, 32'd100);
        tick(99);
        chk("p3_rewrite_99", 32'(p_dat), 32'h03);
        tick(1);
        chk("p3_rewrite_100", 32'(p_dat), 32'h0B);
        wr(32'h00, 32'd0);
        p_pin[3] = 1'b0;
        tick(5);
        chk("p3_low", 32'(p_dat), 32'h03);
        wr(32'h04, 32'hFFFF_FFFF);
        tick(2);
        chk("irq_idle", 32'(irq), 32'd0);

        // bus map and unmapped offsets
        rd(32'h0C, "level", 32'h0000_0003);
        rd(32'h40, "unmapped_rd", 32'd0);
        wr(32'h40, 32'hFFFF_FFFF);
        tick(1);
        chk("ack_drop", 32'(bus_if.sys_ack), 32'd0);
        rd(32'h00, "db_len_kept", 32'd0);
        rd(32'h08, "mask_kept", 32'h0000_FF00);
        rd(32'h04, "status_kept", 32'd0);

        // reset during a debounce count
        wr(32'h00, 32'd20);
        n_pin[0] = 1'b1;
        tick(10);
        rst = 1'b1;
        n_pin[0] = 1'b0;
        tick(2);
        chk("mid_p_dat", 32'(p_dat), 32'd0);
        chk("mid_n_dat", 32'(n_dat), 32'd0);
        chk("mid_irq", 32'(irq), 32'd0);
        chk("mid_ack", 32'(bus_if.sys_ack), 32'd0);
        chk("mid_rdata", bus_if.sys_rdata, 32'd0);
        chk("mid_err", 32'(bus_if.sys_err), 32'd0);
        rst = 1'b0;
        tick(5);
        rd(32'h04, "status_post_rst", 32'h0000_0003);
        rd(32'h0C, "level_post_rst", 32'h0000_0003);
        rd(32'h00, "db_len_post_rst", 32'd0);
        rd(32'h08, "mask_post_rst", 32'd0);
        chk("irq_post_rst", 32'(irq), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
